// File: rtl/mcu51_timer_if.sv
// mcu51_timer_if: CPU-side special-function-register access to one timer's
// TL/TH pair. The CPU (master) drives write data and the two byte-write
// strobes and reads back the live counter halves; the timer core is the slave.
interface mcu51_timer_if;
    logic [7:0] din;
    logic       tl_we;
    logic       th_we;
    logic [7:0] tl;
    logic [7:0] th;

    modport master (
        output din,
        output tl_we,
        output th_we,
        input  tl,
        input  th
    );

    modport slave (
        input  din,
        input  tl_we,
        input  th_we,
        output tl,
        output th
    );
endinterface

// File: rtl/mcu51_timer.sv
// mcu51_timer: one 8051 Timer/Counter core (TLx/THx plus overflow pulses).
// Counts machine-cycle ticks (C/T=0) or synchronized falling edges of the
// external Tx pin (C/T=1) in modes 00 (13-bit), 01 (16-bit) and 10 (8-bit
// auto-reload). All state changes on the falling edge of clk, the same edge
// the surrounding SFR registers use; reset is synchronous and active-low.
// Optional feature macro: TIMER_MODE3_EN
//   defined   -> mode 11 splits into an 8-bit TL timer/counter (tf_set) and an
//                8-bit TH machine-cycle timer gated by th_tr (th_tf_set).
//   undefined -> mode 11 freezes the counter, th_tf_set is tied low and th_tr
//                is ignored.
module mcu51_timer #(
    parameter int PRESCALE = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          tmod_nib,
    input  logic                tr,
    input  logic                int_n,
    input  logic                t_pin,
    input  logic                th_tr,
    mcu51_timer_if.slave        bus,
    output logic                tf_set,
    output logic                th_tf_set
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

    // Registered state
    logic [PW-1:0] r_prescale;
    logic          r_pinSync0;
    logic          r_pinSync1;
    logic          r_pinPrev;
    logic [7:0]    r_tl;
    logic [7:0]    r_th;
    logic          r_tfSet;

    // Decoded control and tick qualification
    logic          w_gate;
    logic          w_ct;
    logic [1:0]    w_mode;
    logic          w_timerTick;
    logic          w_pinTick;
    logic          w_tick;
    logic          w_run;
    logic          w_count;
    logic          w_anyWe;

    // Candidate increments and overflow detects for each counter width
    logic [12:0]   w_inc13;
    logic [15:0]   w_inc16;
    logic [7:0]    w_tlInc;
    logic          w_full13;
    logic          w_full16;
    logic          w_tlFull;

    // Next-state values
    logic [7:0]    w_tlNext;
    logic [7:0]    w_thNext;
    logic          w_tfNext;

`ifdef TIMER_MODE3_EN
    logic          r_thTfSet;
    logic          w_thCount;
    logic [7:0]    w_thInc;
    logic          w_thTfNext;
`else
    logic          w_unusedThTr;
`endif

    assign w_gate  = tmod_nib[3];
    assign w_ct    = tmod_nib[2];
    assign w_mode  = tmod_nib[1:0];
    assign w_anyWe = bus.tl_we | bus.th_we;

    // A machine-cycle tick is the last prescaler state; the pin tick is the
    // synchronized high-to-low transition seen by the previous-value register.
    assign w_timerTick = (r_prescale == PW'(PRESCALE - 1));
    assign w_pinTick   = r_pinPrev & ~r_pinSync1;
    assign w_tick      = w_ct ? w_pinTick : w_timerTick;
    assign w_run       = tr & (~w_gate | int_n);
    assign w_count     = w_tick & w_run;

    assign w_inc13  = {r_th, r_tl[4:0]} + 13'd1;
    assign w_inc16  = {r_th, r_tl} + 16'd1;
    assign w_tlInc  = r_tl + 8'd1;
    assign w_full13 = ({r_th, r_tl[4:0]} == 13'h1FFF);
    assign w_full16 = ({r_th, r_tl} == 16'hFFFF);
    assign w_tlFull = (r_tl == 8'hFF);

`ifdef TIMER_MODE3_EN
    // In split mode TH runs from machine cycles only, gated by th_tr alone.
    assign w_thCount = w_timerTick & th_tr;
    assign w_thInc   = r_th + 8'd1;
`else
    assign w_unusedThTr = th_tr;
`endif

    // Free-running machine-cycle prescaler, independent of the run bit.
    always_ff @(negedge clk) begin
        if (!reset) begin
            r_prescale <= '0;
        end else if (w_timerTick) begin
            r_prescale <= '0;
        end else begin
            r_prescale <= r_prescale + PW'(1);
        end
    end

    // Two-flop synchronizer plus previous-value register for the Tx pin;
    // all three idle high so a pin held low through reset is not an edge.
    always_ff @(negedge clk) begin
        if (!reset) begin
            r_pinSync0 <= 1'b1;
            r_pinSync1 <= 1'b1;
            r_pinPrev  <= 1'b1;
        end else begin
            r_pinSync0 <= t_pin;
            r_pinSync1 <= r_pinSync0;
            r_pinPrev  <= r_pinSync1;
        end
    end

    // Counter next-state: count per mode, then let CPU writes override.
    // A write to any half taking part in this cycle's count drops the whole
    // count, so the other half holds and no overflow pulse is produced.
    always_comb begin
        w_tlNext = r_tl;
        w_thNext = r_th;
        w_tfNext = 1'b0;
`ifdef TIMER_MODE3_EN
        w_thTfNext = 1'b0;
`endif
        if (w_count) begin
            case (w_mode)
                2'b00: begin
                    if (!w_anyWe) begin
                        w_thNext = w_inc13[12:5];
                        w_tlNext = {r_tl[7:5], w_inc13[4:0]};
                        w_tfNext = w_full13;
                    end
                end
                2'b01: begin
                    if (!w_anyWe) begin
                        w_thNext = w_inc16[15:8];
                        w_tlNext = w_inc16[7:0];
                        w_tfNext = w_full16;
                    end
                end
                2'b10: begin
                    if (!bus.tl_we) begin
                        w_tlNext = w_tlFull ? r_th : w_tlInc;
                        w_tfNext = w_tlFull;
                    end
                end
                default: begin
`ifdef TIMER_MODE3_EN
                    if (!bus.tl_we) begin
                        w_tlNext = w_tlInc;
                        w_tfNext = w_tlFull;
                    end
`endif
                end
            endcase
        end
`ifdef TIMER_MODE3_EN
        if ((w_mode == 2'b11) && w_thCount && !bus.th_we) begin
            w_thNext   = w_thInc;
            w_thTfNext = (r_th == 8'hFF);
        end
`endif
        if (bus.tl_we) begin
            w_tlNext = bus.din;
        end
        if (bus.th_we) begin
            w_thNext = bus.din;
        end
    end

    // Counter halves and the single-cycle overflow pulse register together,
    // so tf_set is high exactly in the cycle the wrapped value appears.
    always_ff @(negedge clk) begin
        if (!reset) begin
            r_tl    <= 8'h00;
            r_th    <= 8'h00;
            r_tfSet <= 1'b0;
        end else begin
            r_tl    <= w_tlNext;
            r_th    <= w_thNext;
            r_tfSet <= w_tfNext;
        end
    end

`ifdef TIMER_MODE3_EN
    // Split-mode TH overflow pulse.
    always_ff @(negedge clk) begin
        if (!reset) begin
            r_thTfSet <= 1'b0;
        end else begin
            r_thTfSet <= w_thTfNext;
        end
    end

    assign th_tf_set = r_thTfSet;
`else
    assign th_tf_set = 1'b0;
`endif

    assign bus.tl = r_tl;
    assign bus.th = r_th;
    assign tf_set = r_tfSet;

endmodule

// File: tb/tb_mcu51_timer.sv
// tb_mcu51_timer: directed bench for mcu51_timer with PRESCALE=12.
// The DUT updates on the falling clock edge; the bench drives and samples
// right after each rising edge, so one step() is exactly one active edge.
// After resetDut() the prescaler is 0, so machine-cycle ticks land on
// post-reset active edges 12, 24, 36, ...
module tb_mcu51_timer;

    logic       clk;
    logic       reset;
    logic [3:0] tmod_nib;
    logic       tr;
    logic       int_n;
    logic       t_pin;
    logic       th_tr;
    logic       tf_set;
    logic       th_tf_set;

    int total;
    int bad;

    mcu51_timer_if bus ();

    mcu51_timer #(.PRESCALE(12)) dut (
        .clk       (clk),
        .reset     (reset),
        .tmod_nib  (tmod_nib),
        .tr        (tr),
        .int_n     (int_n),
        .t_pin     (t_pin),
        .th_tr     (th_tr),
        .bus       (bus),
        .tf_set    (tf_set),
        .th_tf_set (th_tf_set)
    );

    // Clock: falling edges at 5, 15, ...; rising edges at 10, 20, ...
    initial clk = 1'b1;
    always #5 clk = ~clk;

    // Advance by n active (falling) edges, ending just after a rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
    endtask

    // Two reset edges with quiet inputs; the next step is post-reset edge 1.
    task automatic resetDut();
        reset     = 1'b0;
        tr        = 1'b0;
        th_tr     = 1'b0;
        int_n     = 1'b1;
        t_pin     = 1'b1;
        bus.tl_we = 1'b0;
        bus.th_we = 1'b0;
        bus.din   = 8'h00;
        step(2);
        reset = 1'b1;
    endtask

    // One-cycle CPU byte writes.
    task automatic writeTl(input logic [7:0] d);
        bus.din   = d;
        bus.tl_we = 1'b1;
        step(1);
        bus.tl_we = 1'b0;
    endtask

    task automatic writeTh(input logic [7:0] d);
        bus.din   = d;
        bus.th_we = 1'b1;
        step(1);
        bus.th_we = 1'b0;
    endtask

    // Reset clears everything and beats a concurrent write; idle with tr=0 holds 0.
    task automatic test_reset();
        resetDut();
        tmod_nib = 4'b0001;
        writeTh(8'h34);
        writeTl(8'h12);
        total++;
        if (bus.tl !== 8'h12 || bus.th !== 8'h34) begin
            bad++;
            $display("[TB] FAIL preload: got th/tl %h/%h want 34/12", bus.th, bus.tl);
        end
        reset     = 1'b0;
        tr        = 1'b1;
        bus.din   = 8'hAA;
        bus.tl_we = 1'b1;
        bus.th_we = 1'b1;
        step(2);
        total++;
        if (bus.tl !== 8'h00 || bus.th !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_regs: got th/tl %h/%h want 00/00", bus.th, bus.tl);
        end
        total++;
        if (tf_set !== 1'b0 || th_tf_set !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_flags: got tf/thtf %b/%b want 0/0", tf_set, th_tf_set);
        end
        reset     = 1'b1;
        tr        = 1'b0;
        bus.tl_we = 1'b0;
        bus.th_we = 1'b0;
        step(50);
        total++;
        if (bus.tl !== 8'h00 || bus.th !== 8'h00) begin
            bad++;
            $display("[TB] FAIL idle_tr0: got th/tl %h/%h want 00/00", bus.th, bus.tl);
        end
    endtask

    // Mode 01 timer: FFFE -> FFFF at edge 12 -> 0000 with tf_set at edge 24.
    task automatic test_mode01();
        int pulses;
        resetDut();
        tmod_nib = 4'b0001;
        writeTh(8'hFF);
        writeTl(8'hFE);
        tr = 1'b1;
        step(9);
        total++;
        if (bus.tl !== 8'hFE) begin
            bad++;
            $display("[TB] FAIL m01_before_tick: got tl %h want FE", bus.tl);
        end
        step(1);
        total++;
        if (bus.tl !== 8'hFF || bus.th !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL m01_first_tick: got th/tl %h/%h want FF/FF", bus.th, bus.tl);
        end
        pulses = 0;
        for (int i = 0; i < 11; i++) begin
            step(1);
            if (tf_set === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0 || bus.tl !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL m01_hold: got pulses=%0d tl=%h want 0 FF", pulses, bus.tl);
        end
        step(1);
        total++;
        if (bus.tl !== 8'h00 || bus.th !== 8'h00 || tf_set !== 1'b1) begin
            bad++;
            $display("[TB] FAIL m01_overflow: got th/tl/tf %h/%h/%b want 00/00/1", bus.th, bus.tl, tf_set);
        end
        step(1);
        total++;
        if (tf_set !== 1'b0) begin
            bad++;
            $display("[TB] FAIL m01_pulse_len: got tf %b want 0", tf_set);
        end
    endtask

    // Mode 10 auto-reload: overflow at edge 24, the next one 16 ticks later.
    task automatic test_mode10();
        int pulses;
        resetDut();
        tmod_nib = 4'b0010;
        writeTh(8'hF0);
        writeTl(8'hFE);
        tr = 1'b1;
        step(10);
        total++;
        if (bus.tl !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL m10_first_tick: got tl %h want FF", bus.tl);
        end
        step(12);
        total++;
        if (bus.tl !== 8'hF0 || bus.th !== 8'hF0 || tf_set !== 1'b1) begin
            bad++;
            $display("[TB] FAIL m10_reload: got th/tl/tf %h/%h/%b want F0/F0/1", bus.th, bus.tl, tf_set);
        end
        pulses = 0;
        for (int i = 0; i < 191; i++) begin
            step(1);
            if (tf_set === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0 || bus.tl !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL m10_between: got pulses=%0d tl=%h want 0 FF", pulses, bus.tl);
        end
        step(1);
        total++;
        if (bus.tl !== 8'hF0 || tf_set !== 1'b1) begin
            bad++;
            $display("[TB] FAIL m10_second_reload: got tl/tf %h/%b want F0/1", bus.tl, tf_set);
        end
    endtask

    // Mode 00 with GATE: int_n low blocks counting, then 1FFF wraps keeping tl[7:5].
    task automatic test_gate();
        int pulses;
        resetDut();
        tmod_nib = 4'b1000;
        writeTh(8'hFF);
        writeTl(8'hBF);
        tr    = 1'b1;
        int_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 98; i++) begin
            step(1);
            if (tf_set === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0 || bus.tl !== 8'hBF || bus.th !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL gate_blocked: got pulses=%0d th/tl %h/%h want 0 FF/BF", pulses, bus.th, bus.tl);
        end
        int_n = 1'b1;
        step(7);
        total++;
        if (bus.tl !== 8'hBF) begin
            bad++;
            $display("[TB] FAIL gate_before_tick: got tl %h want BF", bus.tl);
        end
        step(1);
        total++;
        if (bus.tl !== 8'hA0 || bus.th !== 8'h00 || tf_set !== 1'b1) begin
            bad++;
            $display("[TB] FAIL m00_overflow: got th/tl/tf %h/%h/%b want 00/A0/1", bus.th, bus.tl, tf_set);
        end
    endtask

    // Counter mode: each falling pin edge increments on the third active edge.
    task automatic test_counter();
        resetDut();
        tmod_nib = 4'b0101;
        tr       = 1'b1;
        step(3);
        for (int i = 0; i < 3; i++) begin
            t_pin = 1'b0;
            step(2);
            total++;
            if (bus.tl !== 8'(i)) begin
                bad++;
                $display("[TB] FAIL cnt_early_%0d: got tl %h want %h", i, bus.tl, 8'(i));
            end
            step(1);
            total++;
            if (bus.tl !== 8'(i + 1)) begin
                bad++;
                $display("[TB] FAIL cnt_land_%0d: got tl %h want %h", i, bus.tl, 8'(i + 1));
            end
            step(1);
            t_pin = 1'b1;
            step(4);
        end
        total++;
        if (bus.tl !== 8'h03 || bus.th !== 8'h00) begin
            bad++;
            $display("[TB] FAIL cnt_final: got th/tl %h/%h want 00/03", bus.th, bus.tl);
        end
    endtask

    // TL write on the FFFF tick cycle drops the count and the overflow pulse.
    task automatic test_collision();
        int pulses;
        resetDut();
        tmod_nib = 4'b0001;
        writeTh(8'hFF);
        writeTl(8'hFF);
        tr = 1'b1;
        step(9);
        bus.din   = 8'h55;
        bus.tl_we = 1'b1;
        step(1);
        bus.tl_we = 1'b0;
        total++;
        if (bus.tl !== 8'h55 || bus.th !== 8'hFF || tf_set !== 1'b0) begin
            bad++;
            $display("[TB] FAIL collide: got th/tl/tf %h/%h/%b want FF/55/0", bus.th, bus.tl, tf_set);
        end
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (tf_set === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0 || bus.tl !== 8'h56 || bus.th !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL collide_after: got pulses=%0d th/tl %h/%h want 0 FF/56", pulses, bus.th, bus.tl);
        end
    endtask

    // Mode 11: split timers when the feature is built in, frozen otherwise.
    task automatic test_mode3();
        resetDut();
        tmod_nib = 4'b0011;
        writeTh(8'hFF);
        writeTl(8'h10);
        th_tr = 1'b1;
`ifdef TIMER_MODE3_EN
        tr = 1'b0;
        step(10);
        total++;
        if (bus.th !== 8'h00 || th_tf_set !== 1'b1 || bus.tl !== 8'h10 || tf_set !== 1'b0) begin
            bad++;
            $display("[TB] FAIL m3_th_overflow: got th/thtf/tl/tf %h/%b/%h/%b want 00/1/10/0", bus.th, th_tf_set, bus.tl, tf_set);
        end
        step(1);
        total++;
        if (th_tf_set !== 1'b0) begin
            bad++;
            $display("[TB] FAIL m3_thtf_len: got thtf %b want 0", th_tf_set);
        end
        tr = 1'b1;
        step(11);
        total++;
        if (bus.tl !== 8'h11 || bus.th !== 8'h01) begin
            bad++;
            $display("[TB] FAIL m3_both_count: got th/tl %h/%h want 01/11", bus.th, bus.tl);
        end
`else
        tr = 1'b1;
        step(10);
        total++;
        if (bus.th !== 8'hFF || bus.tl !== 8'h10 || th_tf_set !== 1'b0 || tf_set !== 1'b0) begin
            bad++;
            $display("[TB] FAIL m3_hold: got th/tl/thtf/tf %h/%h/%b/%b want FF/10/0/0", bus.th, bus.tl, th_tf_set, tf_set);
        end
        writeTl(8'h77);
        total++;
        if (bus.tl !== 8'h77) begin
            bad++;
            $display("[TB] FAIL m3_write: got tl %h want 77", bus.tl);
        end
        step(12);
        total++;
        if (bus.tl !== 8'h77 || bus.th !== 8'hFF) begin
            bad++;
            $display("[TB] FAIL m3_hold_after: got th/tl %h/%h want FF/77", bus.th, bus.tl);
        end
`endif
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        tmod_nib  = 4'b0000;
        tr        = 1'b0;
        int_n     = 1'b1;
        t_pin     = 1'b1;
        th_tr     = 1'b0;
        bus.din   = 8'h00;
        bus.tl_we = 1'b0;
        bus.th_we = 1'b0;

        test_reset();
        test_mode01();
        test_mode10();
        test_gate();
        test_counter();
        test_collision();
        test_mode3();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
